// File: rtl/single_bit_half_adder_if.sv
// Operand/result bundle for one bit slice of the hybrid adder.
// The master drives the operands and consumes the results; the slave is the slice itself.
interface single_bit_half_adder_if;
   logic in_valid;
   logic a;
   logic b;
   logic cy_in;
   logic sum;
   logic cy_out;
   logic gen;
   logic prop;
   logic out_valid;

   modport master (
      output in_valid,
      output a,
      output b,
      output cy_in,
      input  sum,
      input  cy_out,
      input  gen,
      input  prop,
      input  out_valid
   );

   modport slave (
      input  in_valid,
      input  a,
      input  b,
      input  cy_in,
      output sum,
      output cy_out,
      output gen,
      output prop,
      output out_valid
   );
endinterface

// File: rtl/single_bit_half_adder.sv
// Single-bit sum/carry leaf cell. It produces sum and carry-out, plus the
// generate/propagate terms consumed by the carry-lookahead groups above it.
// REG_OUT=1 gives registered results one cycle after an accepted input.
// REG_OUT=0 makes the results combinational while out_valid stays registered.
module single_bit_half_adder #(
   parameter bit REG_OUT = 1'b1
) (
   input  logic                        clk,
   input  logic                        rst,
   single_bit_half_adder_if.slave      bus
);

   logic sum_c;
   logic cy_out_c;
   logic gen_c;
   logic prop_c;

   logic sum_d;
   logic sum_q;
   logic cy_out_d;
   logic cy_out_q;
   logic gen_d;
   logic gen_q;
   logic prop_d;
   logic prop_q;
   logic out_valid_d;
   logic out_valid_q;

   // Full-sum truth table, built from the generate/propagate terms.
   always_comb begin
      gen_c    = bus.a & bus.b;
      prop_c   = bus.a ^ bus.b;
      sum_c    = prop_c ^ bus.cy_in;
      cy_out_c = gen_c | (prop_c & bus.cy_in);
   end

   // Next-state logic. Reset wins over in_valid. Registers capture only
   // qualified inputs, so unqualified (possibly X) operands never reach the flops.
   always_comb begin
      sum_d       = sum_q;
      cy_out_d    = cy_out_q;
      gen_d       = gen_q;
      prop_d      = prop_q;
      out_valid_d = 1'b0;
      if (rst) begin
         sum_d    = 1'b0;
         cy_out_d = 1'b0;
         gen_d    = 1'b0;
         prop_d   = 1'b0;
      end else if (bus.in_valid) begin
         sum_d       = sum_c;
         cy_out_d    = cy_out_c;
         gen_d       = gen_c;
         prop_d      = prop_c;
         out_valid_d = 1'b1;
      end
   end

   // Result and valid registers.
   always_ff @(posedge clk) begin
      sum_q       <= sum_d;
      cy_out_q    <= cy_out_d;
      gen_q       <= gen_d;
      prop_q      <= prop_d;
      out_valid_q <= out_valid_d;
   end

   assign bus.out_valid = out_valid_q;

   generate
      if (REG_OUT) begin : g_reg_out
         assign bus.sum    = sum_q;
         assign bus.cy_out = cy_out_q;
         assign bus.gen    = gen_q;
         assign bus.prop   = prop_q;
      end else begin : g_comb_out
         // Pass the live result through only when qualified. Otherwise present
         // the last captured result, so X on idle inputs stays off the outputs.
         always_comb begin
            bus.sum    = bus.in_valid ? sum_c    : sum_q;
            bus.cy_out = bus.in_valid ? cy_out_c : cy_out_q;
            bus.gen    = bus.in_valid ? gen_c    : gen_q;
            bus.prop   = bus.in_valid ? prop_c   : prop_q;
         end
      end
   endgenerate

endmodule

// File: tb/tb_single_bit_half_adder.sv
// Bench for the registered single-bit slice: directed cases followed by random traffic.
module tb_single_bit_half_adder;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   // Expected-output model state.
   logic exp_sum;
   logic exp_cy;
   logic exp_gen;
   logic exp_prop;
   logic exp_valid;

   single_bit_half_adder_if bus_if ();

   single_bit_half_adder #(.REG_OUT(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   // Drive one cycle, update the model from arithmetic on the ones count, then check.
   task automatic step(input string tag, input logic r, input logic v,
                       input logic ia, input logic ib, input logic ic);
      int ones;
      int ab;
      rst             = r;
      bus_if.in_valid = v;
      bus_if.a        = ia;
      bus_if.b        = ib;
      bus_if.cy_in    = ic;
      @(posedge clk);
      #1;
      ones = int'(ia) + int'(ib) + int'(ic);
      ab   = int'(ia) + int'(ib);
      if (r) begin
         exp_sum   = 1'b0;
         exp_cy    = 1'b0;
         exp_gen   = 1'b0;
         exp_prop  = 1'b0;
         exp_valid = 1'b0;
      end else if (v) begin
         exp_sum   = (ones % 2) == 1;
         exp_cy    = ones >= 2;
         exp_gen   = ab == 2;
         exp_prop  = ab == 1;
         exp_valid = 1'b1;
      end else begin
         exp_valid = 1'b0;
      end
      chk({tag, ".sum"},       bus_if.sum,       exp_sum);
      chk({tag, ".cy_out"},    bus_if.cy_out,    exp_cy);
      chk({tag, ".gen"},       bus_if.gen,       exp_gen);
      chk({tag, ".prop"},      bus_if.prop,      exp_prop);
      chk({tag, ".out_valid"}, bus_if.out_valid, exp_valid);
   endtask

   initial begin
      logic [2:0] v3;
      total           = 0;
      bad             = 0;
      exp_sum         = 1'b0;
      exp_cy          = 1'b0;
      exp_gen         = 1'b0;
      exp_prop        = 1'b0;
      exp_valid       = 1'b0;
      rst             = 1'b1;
      bus_if.in_valid = 1'b1;
      bus_if.a        = 1'b1;
      bus_if.b        = 1'b1;
      bus_if.cy_in    = 1'b1;

      // Reset held for two edges with valid all-ones inputs.
      step("reset0", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      step("reset1", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

      // Single operands.
      step("a_only", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      step("b_only", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

      // Carry generation and propagation.
      step("gen110",  1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      step("prop101", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      step("all111",  1'b0, 1'b1, 1'b1, 1'b1, 1'b1);

      // Exhaustive back-to-back sweep.
      for (int i = 0; i < 8; i++) begin
         v3 = i[2:0];
         step($sformatf("sweep%0d", i), 1'b0, 1'b1, v3[2], v3[1], v3[0]);
      end

      // Hold on unqualified inputs.
      step("hold_load", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      step("hold_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step("hold_idle2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      // Reset mid-stream, then resume.
      step("mid_rst", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      step("post_rst", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);

      // Random traffic with occasional resets and idle cycles.
      for (int i = 0; i < 300; i++) begin
         step($sformatf("rand%0d", i),
              ($urandom_range(0, 19) == 0),
              ($urandom_range(0, 3) != 0),
              1'($urandom), 1'($urandom), 1'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/single_bit_half_adder.md
Name: single_bit_half_adder

Overview:
- Single-bit sum/carry slice used as the leaf cell of the hybrid adder.
- Takes operand bits a and b plus an incoming carry cy_in.
- Produces the registered sum bit, plus carry-out and generate/propagate terms that the carry-lookahead groups above it consume.
- Fully synchronous: one clock, one-cycle latency, valid-qualified.

Parameters:
- REG_OUT, 1: 1 = outputs registered (1-cycle latency); 0 = sum/cy_out/gen/prop combinational, out_valid still registered.

Ports:
- clk  input  1  system clock, rising edge active
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  a/b/cy_in are valid this cycle
- a  input  1  operand bit A
- b  input  1  operand bit B
- cy_in  input  1  carry into this bit position
- sum  output  1  a XOR b XOR cy_in
- cy_out  output  1  (a AND b) OR (cy_in AND (a XOR b))
- gen  output  1  generate term, a AND b
- prop  output  1  propagate term, a XOR b
- out_valid  output  1  sum/cy_out/gen/prop hold a valid result

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset: on a rising clk edge with rst=1, sum, cy_out, gen, prop and out_valid all go to 0.
  - rst has priority over in_valid in the same cycle.
  - The input sampled in that cycle is discarded.
- Arithmetic: full-sum truth table over (a,b,cy_in):
  - sum = 1 for an odd count of ones.
  - cy_out = 1 for two or more ones.
  - gen = a&b; prop = a^b.
  - No width growth beyond the 1-bit sum plus 1-bit carry.
- REG_OUT=1:
  - Inputs sampled on the clk edge where in_valid=1 and rst=0.
  - Results appear after that edge; out_valid=1 for exactly the following cycle per accepted input.
  - Back-to-back valid inputs give back-to-back results, one per cycle, with no bubbles.
- in_valid=0 (no reset):
  - out_valid drops to 0 at the next edge.
  - sum/cy_out/gen/prop hold their last values and do not update from unqualified inputs.
- REG_OUT=0:
  - sum/cy_out/gen/prop follow the inputs combinationally.
  - out_valid is in_valid registered, reset to 0.
- No backpressure, no internal state other than the output registers; X on inputs while in_valid=0 must not propagate to outputs.
- Reset mid-stream: a valid input on the reset edge produces no result; the next valid input after rst deasserts is processed normally.

Test Plan:
- Reset: rst=1 for two edges with a=b=cy_in=1, in_valid=1 -> all outputs 0, out_valid=0.
- Single-operand cases, one per cycle with in_valid=1:
  - (a,b,cy_in)=(1,0,0) -> sum=1, cy_out=0, prop=1, gen=0
  - (0,1,0) -> sum=1, cy_out=0
- Carry generation and propagation:
  - (1,1,0) -> sum=0, cy_out=1, gen=1, prop=0
  - (1,0,1) -> sum=0, cy_out=1, gen=0, prop=1
  - (1,1,1) -> sum=1, cy_out=1
  - each appears exactly one cycle after its input with out_valid=1.
- Exhaustive back-to-back: all 8 input combinations on consecutive cycles -> 8 consecutive valid results matching the truth table, out_valid continuously 1.
- Hold/qualification: valid (1,1,1) then in_valid=0 with inputs (0,0,0) -> out_valid falls to 0; sum stays 1, cy_out stays 1.
- Reset mid-stream: in_valid=1 with (1,1,0) on the same edge as rst=1 -> outputs 0, out_valid=0; next cycle (0,1,1) with rst=0 -> sum=0, cy_out=1, out_valid=1.
